// File: rtl/result_scanout.sv
// -----------------------------------------------------------------------------
// result_scanout
//   Reads the TW x TH upscaled image back from the result SRAM once the
//   bicubic core is done. The pixels stream out in raster order over a
//   valid/ready interface. A small prefetch FIFO keeps one beat per cycle
//   flowing while the sink applies backpressure.
//
// Optional feature (macro CHECKSUM_EN):
//   When defined, adds o_chksum. It is the 16-bit wrapping sum of every
//   accepted o_out_data, cleared on an accepted start.
//
// Ports
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_start          1-cycle scan request; i_tw/i_th are sampled with it
//   o_sram_re/o_sram_a/i_sram_q
//                    result SRAM read port; data is valid RD_LAT cycles
//                    after the RE cycle
//   o_out_valid/i_out_ready/o_out_data/o_out_x/o_out_y/o_out_last
//                    pixel stream
//   o_busy           high from the cycle after an accepted start until o_fin
//   o_fin            1-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module result_scanout #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 8,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [5:0]        i_tw,
   input  logic [5:0]        i_th,
   output logic              o_sram_re,
   output logic [ADDR_W-1:0] o_sram_a,
   input  logic [DATA_W-1:0] i_sram_q,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic [5:0]        o_out_x,
   output logic [5:0]        o_out_y,
   output logic              o_out_last,
`ifdef CHECKSUM_EN
   output logic [15:0]       o_chksum,
`endif
   output logic              o_busy,
   output logic              o_fin
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int EW = DATA_W + 13;   // {last, y, x, data}

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   state_t            r_state;
   logic [5:0]        r_tw, r_th;
   logic              r_re;
   logic [ADDR_W-1:0] r_a;
   logic [5:0]        r_tx, r_ty;     // coordinates of the read currently on the bus
   logic              r_tlast;
   logic [5:0]        r_nx, r_ny;     // coordinates of the next read to issue
   logic [ADDR_W-1:0] r_na;
   logic              r_busy, r_fin;

   // Tag pipeline that follows each read through the SRAM latency.
   logic [RD_LAT-1:0] r_pv;
   logic [5:0]        r_px [RD_LAT];
   logic [5:0]        r_py [RD_LAT];
   logic              r_pl [RD_LAT];

   logic [EW-1:0]     r_mem [FIFO_DEPTH];
   logic [PW-1:0]     r_wp, r_rp;
   logic [CW-1:0]     r_cnt;
   logic              r_valid;

   logic              w_push, w_pop, w_credit, w_done, w_last_next;
   logic [7:0]        w_inflight, w_total;
   logic [CW-1:0]     w_cnt_next;
   logic [EW-1:0]     w_head, w_head_vis;

   // Credit accounting: every read still in the SRAM pipe owns a FIFO slot,
   // and a pop in this cycle frees a slot for the read decided at this edge.
   always_comb begin
      w_push     = r_pv[RD_LAT-1];
      w_pop      = r_valid & i_out_ready;
      w_inflight = 8'(r_re);
      for (int k = 0; k < RD_LAT; k++) begin
         w_inflight = w_inflight + 8'(r_pv[k]);
      end
      w_total     = 8'(r_cnt) + w_inflight;
      w_credit    = ((w_total - 8'(w_pop)) < 8'(FIFO_DEPTH));
      w_last_next = (r_nx == (r_tw - 6'd1)) && (r_ny == (r_th - 6'd1));
      w_done      = (r_state == S_DRAIN) && (w_inflight == 8'd0) &&
                    (r_cnt == CW'(1)) && w_pop;
      case ({w_push, w_pop})
         2'b10:   w_cnt_next = r_cnt + CW'(1);
         2'b01:   w_cnt_next = r_cnt - CW'(1);
         default: w_cnt_next = r_cnt;
      endcase
      w_head = r_mem[r_rp];
      if (r_valid) begin
         w_head_vis = w_head;
      end else begin
         w_head_vis = {EW{1'b0}};
      end
   end

   // Scan FSM, read issue counters and status outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_tw    <= 6'd0;
         r_th    <= 6'd0;
         r_re    <= 1'b0;
         r_a     <= {ADDR_W{1'b0}};
         r_tx    <= 6'd0;
         r_ty    <= 6'd0;
         r_tlast <= 1'b0;
         r_nx    <= 6'd0;
         r_ny    <= 6'd0;
         r_na    <= {ADDR_W{1'b0}};
         r_busy  <= 1'b0;
         r_fin   <= 1'b0;
      end else begin
         r_re <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_fin <= 1'b0;
               if (i_start) begin
                  r_tw   <= i_tw;
                  r_th   <= i_th;
                  r_busy <= 1'b1;
                  if ((i_tw == 6'd0) || (i_th == 6'd0)) begin
                     r_state <= S_FIN;
                  end else begin
                     // The first read goes out immediately; the FIFO is empty.
                     r_re    <= 1'b1;
                     r_a     <= {ADDR_W{1'b0}};
                     r_tx    <= 6'd0;
                     r_ty    <= 6'd0;
                     r_tlast <= (i_tw == 6'd1) && (i_th == 6'd1);
                     r_na    <= ADDR_W'(1);
                     if (i_tw == 6'd1) begin
                        r_nx <= 6'd0;
                        r_ny <= 6'd1;
                     end else begin
                        r_nx <= 6'd1;
                        r_ny <= 6'd0;
                     end
                     r_state <= ((i_tw == 6'd1) && (i_th == 6'd1)) ? S_DRAIN : S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (w_credit) begin
                  r_re    <= 1'b1;
                  r_a     <= r_na;
                  r_tx    <= r_nx;
                  r_ty    <= r_ny;
                  r_tlast <= w_last_next;
                  r_na    <= r_na + ADDR_W'(1);
                  if (r_nx == (r_tw - 6'd1)) begin
                     r_nx <= 6'd0;
                     r_ny <= r_ny + 6'd1;
                  end else begin
                     r_nx <= r_nx + 6'd1;
                  end
                  if (w_last_next) begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (w_done) begin
                  r_state <= S_FIN;
                  r_fin   <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            S_FIN: begin
               // A drained scan enters with FIN already raised; an empty
               // image raises it here, one cycle later.
               if (r_fin) begin
                  r_fin   <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_fin  <= 1'b1;
                  r_busy <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Delay the read tags so they line up with the returning SRAM data.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pv <= {RD_LAT{1'b0}};
         for (int k = 0; k < RD_LAT; k++) begin
            r_px[k] <= 6'd0;
            r_py[k] <= 6'd0;
            r_pl[k] <= 1'b0;
         end
      end else begin
         r_pv[0] <= r_re;
         r_px[0] <= r_tx;
         r_py[0] <= r_ty;
         r_pl[0] <= r_tlast;
         for (int k = 1; k < RD_LAT; k++) begin
            r_pv[k] <= r_pv[k-1];
            r_px[k] <= r_px[k-1];
            r_py[k] <= r_py[k-1];
            r_pl[k] <= r_pl[k-1];
         end
      end
   end

   // Prefetch FIFO storage.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wp] <= {r_pl[RD_LAT-1], r_py[RD_LAT-1], r_px[RD_LAT-1], i_sram_q};
      end
   end

   // Prefetch FIFO pointers, occupancy and registered valid flag.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wp    <= {PW{1'b0}};
         r_rp    <= {PW{1'b0}};
         r_cnt   <= {CW{1'b0}};
         r_valid <= 1'b0;
      end else begin
         if (w_push) begin
            r_wp <= (r_wp == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : (r_wp + PW'(1));
         end
         if (w_pop) begin
            r_rp <= (r_rp == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : (r_rp + PW'(1));
         end
         r_cnt   <= w_cnt_next;
         r_valid <= (w_cnt_next != {CW{1'b0}});
      end
   end

`ifdef CHECKSUM_EN
   logic [15:0] r_chksum;

   // Running sum of accepted pixels, cleared by each accepted start.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_chksum <= 16'd0;
      end else if ((r_state == S_IDLE) && i_start) begin
         r_chksum <= 16'd0;
      end else if (w_pop) begin
         r_chksum <= r_chksum + 16'(w_head[DATA_W-1:0]);
      end
   end

   assign o_chksum = r_chksum;
`endif

   assign o_sram_re   = r_re;
   assign o_sram_a    = r_a;
   assign o_out_valid = r_valid;
   assign o_out_data  = w_head_vis[DATA_W-1:0];
   assign o_out_x     = w_head_vis[DATA_W+5:DATA_W];
   assign o_out_y     = w_head_vis[DATA_W+11:DATA_W+6];
   assign o_out_last  = w_head_vis[DATA_W+12];
   assign o_busy      = r_busy;
   assign o_fin       = r_fin;

endmodule
